mmio_timer: RTL and testbench
=============================

MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter BASE_ADDR, default 9'h180: word address of register 0; block decodes BASE_ADDR..BASE_ADDR+3.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 mem_cmd  input  2  bus command from CPU: 2'b00 MNONE, 2'b01 MREAD, 2'b10 MWRITE; 2'b11 treated as MNONE.
REQ-005 mem_addr  input  9  word address from CPU.
REQ-006 write_data  input  16  CPU store data.
REQ-007 read_data  output  16  registered register-read value.
REQ-008 read_en  output  1  combinational drive enable for top-level tri-state onto shared read bus.
REQ-009 irq  output  1  interrupt request, level.

Function
REQ-010 hit SHALL be 1 when mem_addr[8:2]==BASE_ADDR[8:2]; reg index = mem_addr[1:0].
REQ-011 Register map SHALL be: 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS.
REQ-012 CTRL SHALL hold bit0 EN, bit1 AUTO_RELOAD, bit2 IE, bits[15:8] PRESCALE; bits[7:3] SHALL read 0, writes ignored.
REQ-013 STATUS bit0 SHALL be MATCH (sticky); bits[15:1] read 0.
REQ-014 read_en SHALL equal hit & (mem_cmd==MREAD), no latency.
REQ-015 On posedge with hit & MREAD, read_data SHALL load selected register's pre-edge value; otherwise hold; one-cycle read latency, same as RAM.
REQ-016 On posedge with hit & MWRITE, indexed register SHALL load write_data (CTRL masked per REQ-012).
REQ-017 Writing STATUS SHALL clear MATCH when write_data[0]==1 (write-1-to-clear); write_data[0]==0 no effect.
REQ-018 Accesses with hit==0 or mem_cmd MNONE/2'b11 SHALL change no state and leave read_data unchanged.
REQ-019 8-bit prescaler pre SHALL, while EN==1, count 0..PRESCALE; tick=1 in cycle pre==PRESCALE, then pre<=0; PRESCALE=0 gives tick every cycle.
REQ-020 While EN==0, pre SHALL hold 0 and tick SHALL be 0.
REQ-021 Any CTRL write SHALL reset pre to 0 that edge.
REQ-022 On tick: if COUNT==COMPARE, MATCH<=1 and COUNT<=(AUTO_RELOAD ? 0 : COUNT+1); else COUNT<=COUNT+1.
REQ-023 COUNT SHALL wrap 16'hFFFF->16'h0000 without setting MATCH unless COMPARE matched.
REQ-024 CPU write to COUNT SHALL win over same-edge tick increment/reload; match test on that tick still uses pre-edge COUNT.
REQ-025 MATCH set by tick and W1C on same edge: set SHALL win (MATCH=1).
REQ-026 irq SHALL equal MATCH & IE, combinational from registers.

Reset
REQ-027 On reset: CTRL, COUNT, COMPARE, MATCH, pre, read_data SHALL be 0; irq 0; read_en still follows REQ-014.
REQ-028 Reset SHALL take priority over any same-edge bus write or tick; operation mid-count SHALL abort with no residual state.

Verification
REQ-029 Reset then MREAD each of 0x180..0x183 -> read_en=1 each cycle, read_data=16'h0000 one cycle later.
REQ-030 Write COMPARE=3, CTRL=16'h0005 (EN,IE,PRESCALE=0) -> COUNT 0,1,2,3 on successive cycles; MATCH and irq rise on edge after COUNT==3 tick; COUNT continues 4.
REQ-031 CTRL=16'h0301 (PRESCALE=3, EN) -> COUNT increments exactly every 4 cycles; CTRL rewrite mid-period restarts 4-cycle period.
REQ-032 COUNT=16'hFFFF, COMPARE=5, EN -> COUNT wraps to 0, MATCH stays 0; AUTO_RELOAD with COMPARE=2 -> sequence 0,1,2,0,1,2, MATCH=1.
REQ-033 MATCH=1, write STATUS=1 on same edge as new match -> MATCH remains 1; write STATUS=1 later -> MATCH 0, irq 0.
REQ-034 MREAD/MWRITE to 0x17F, 0x184, 0x100 -> read_en=0, no register change; reset asserted mid-count -> all registers 0 next edge.

Source files
------------

// File: rtl/mmio_timer.sv
// mmio_timer: word-addressed timer peripheral with prescaler,
// compare match, auto-reload and level interrupt.
module mmio_timer #(
  parameter logic [8:0] BASE_ADDR = 9'h180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        read_en,
  output logic        irq
);

  localparam logic [1:0]  CMD_READ  = 2'b01;
  localparam logic [1:0]  CMD_WRITE = 2'b10;
  localparam logic [1:0]  IDX_CTRL  = 2'd0;
  localparam logic [1:0]  IDX_COUNT = 2'd1;
  localparam logic [1:0]  IDX_CMP   = 2'd2;
  localparam logic [1:0]  IDX_STAT  = 2'd3;
  localparam logic [15:0] CTRL_MASK = 16'hFF07;

  logic [15:0] ctrl_q, ctrl_d;
  logic [15:0] count_q, count_d;
  logic [15:0] cmp_q, cmp_d;
  logic        match_q, match_d;
  logic [7:0]  pre_q, pre_d;
  logic [15:0] rdata_q, rdata_d;

  logic       hit;
  logic       rd_hit;
  logic       wr_hit;
  logic [1:0] idx;
  logic       sel_ctrl;
  logic       sel_count;
  logic       sel_cmp;
  logic       sel_stat;
  logic       wr_ctrl;
  logic       wr_count;
  logic       wr_cmp;
  logic       wr_stat;

  logic       en;
  logic       auto_rld;
  logic       ie;
  logic [7:0] prescale;
  logic       tick;
  logic       cnt_eq;

  // Address decode and bus strobes
  always_comb begin
    hit       = (mem_addr[8:2] == BASE_ADDR[8:2]);
    idx       = mem_addr[1:0];
    rd_hit    = hit & (mem_cmd == CMD_READ);
    wr_hit    = hit & (mem_cmd == CMD_WRITE);
    sel_ctrl  = (idx == IDX_CTRL);
    sel_count = (idx == IDX_COUNT);
    sel_cmp   = (idx == IDX_CMP);
    sel_stat  = (idx == IDX_STAT);
    wr_ctrl   = wr_hit & sel_ctrl;
    wr_count  = wr_hit & sel_count;
    wr_cmp    = wr_hit & sel_cmp;
    wr_stat   = wr_hit & sel_stat;
  end

  // Control fields and prescaler tick
  always_comb begin
    en       = ctrl_q[0];
    auto_rld = ctrl_q[1];
    ie       = ctrl_q[2];
    prescale = ctrl_q[15:8];
    tick     = en & (pre_q == prescale);
    cnt_eq   = (count_q == cmp_q);
  end

  // Prescaler: runs 0..PRESCALE while enabled, restarts on CTRL write
  always_comb begin
    pre_d = pre_q;
    if (!en) begin
      pre_d = 8'd0;
    end else if (tick) begin
      pre_d = 8'd0;
    end else begin
      pre_d = pre_q + 8'd1;
    end
    if (wr_ctrl) begin
      pre_d = 8'd0;
    end
  end

  // Counter: tick advances or reloads, CPU write overrides
  always_comb begin
    count_d = count_q;
    if (tick) begin
      if (cnt_eq && auto_rld) begin
        count_d = 16'd0;
      end else begin
        count_d = count_q + 16'd1;
      end
    end
    if (wr_count) begin
      count_d = write_data;
    end
  end

  // Sticky match flag: W1C, but a new match wins
  always_comb begin
    match_d = match_q;
    if (wr_stat && write_data[0]) begin
      match_d = 1'b0;
    end
    if (tick && cnt_eq) begin
      match_d = 1'b1;
    end
  end

  // Plain configuration registers
  always_comb begin
    ctrl_d = ctrl_q;
    cmp_d  = cmp_q;
    if (wr_ctrl) begin
      ctrl_d = write_data & CTRL_MASK;
    end
    if (wr_cmp) begin
      cmp_d = write_data;
    end
  end

  // Registered readback of pre-edge register values
  always_comb begin
    rdata_d = rdata_q;
    if (rd_hit) begin
      unique case (1'b1)
        sel_ctrl:  rdata_d = ctrl_q;
        sel_count: rdata_d = count_q;
        sel_cmp:   rdata_d = cmp_q;
        sel_stat:  rdata_d = {15'd0, match_q};
        default:   rdata_d = rdata_q;
      endcase
    end
  end

  // State update with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= 16'd0;
      count_q <= 16'd0;
      cmp_q   <= 16'd0;
      match_q <= 1'b0;
      pre_q   <= 8'd0;
      rdata_q <= 16'd0;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      pre_q   <= pre_d;
      rdata_q <= rdata_d;
    end
  end

  assign read_data = rdata_q;
  assign read_en   = rd_hit;
  assign irq       = match_q & ie;

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: scoreboard-driven bench for mmio_timer,
// one task per feature, reads checked one cycle after issue.
module tb_mmio_timer;

  localparam logic [8:0] A_CTRL  = 9'h180;
  localparam logic [8:0] A_COUNT = 9'h181;
  localparam logic [8:0] A_CMP   = 9'h182;
  localparam logic [8:0] A_STAT  = 9'h183;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        read_en;
  logic        irq;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  mmio_timer #(.BASE_ADDR(9'h180)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .read_en    (read_en),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_cmd = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    @(negedge clk);
    mem_cmd = 2'b10;
    mem_addr = a;
    write_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_cmd = 2'b00;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [8:0] a, input logic [15:0] e,
                    input string tag);
    exp_t x;
    @(negedge clk);
    mem_cmd = 2'b01;
    mem_addr = a;
    write_data = 16'h0000;
    #1;
    n_vec++;
    if (read_en !== 1'b1) begin
      n_err++;
      $display("FAIL %s read_en: got %b want 1", tag, read_en);
    end
    x.tag = tag;
    x.val = e;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    n_vec++;
    if (read_data !== x.val) begin
      n_err++;
      $display("FAIL %s read_data: got %h want %h",
               x.tag, read_data, x.val);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (read_data !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_rdata: got %h want 0000", read_data);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq: got %b want 0", irq);
    end
    rd(A_CTRL, 16'h0000, "rst_ctrl");
    rd(A_COUNT, 16'h0000, "rst_count");
    rd(A_CMP, 16'h0000, "rst_cmp");
    rd(A_STAT, 16'h0000, "rst_stat");
  endtask

  task automatic test_regs();
    do_reset();
    wr(A_CTRL, 16'hFFF8);
    rd(A_CTRL, 16'hFF00, "ctrl_mask");
    wr(A_COUNT, 16'hBEEF);
    rd(A_COUNT, 16'hBEEF, "count_rw");
    wr(A_CMP, 16'h1234);
    rd(A_CMP, 16'h1234, "cmp_rw");
    wr(A_STAT, 16'hFFFE);
    rd(A_STAT, 16'h0000, "stat_ro");
  endtask

  task automatic test_count_match();
    do_reset();
    wr(A_CMP, 16'd3);
    wr(A_CTRL, 16'h0005);
    rd(A_COUNT, 16'd0, "cm_c0");
    rd(A_COUNT, 16'd1, "cm_c1");
    rd(A_COUNT, 16'd2, "cm_c2");
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL cm_irq_early: got %b want 0", irq);
    end
    rd(A_COUNT, 16'd3, "cm_c3");
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL cm_irq: got %b want 1", irq);
    end
    rd(A_COUNT, 16'd4, "cm_c4");
    rd(A_STAT, 16'd1, "cm_match");
  endtask

  task automatic test_prescale();
    do_reset();
    wr(A_CTRL, 16'h0301);
    for (int i = 0; i < 4; i++) rd(A_COUNT, 16'd0, "ps_p0");
    for (int i = 0; i < 4; i++) rd(A_COUNT, 16'd1, "ps_p1");
    rd(A_COUNT, 16'd2, "ps_p2");
    wr(A_CTRL, 16'h0301);
    for (int i = 0; i < 4; i++) rd(A_COUNT, 16'd2, "ps_restart");
    rd(A_COUNT, 16'd3, "ps_p3");
  endtask

  task automatic test_wrap();
    do_reset();
    wr(A_COUNT, 16'hFFFF);
    wr(A_CMP, 16'd5);
    wr(A_CTRL, 16'h0001);
    rd(A_COUNT, 16'hFFFF, "wrap_ff");
    rd(A_COUNT, 16'h0000, "wrap_00");
    rd(A_STAT, 16'h0000, "wrap_nomatch");
  endtask

  task automatic test_reload();
    logic [15:0] seq [6];
    seq = '{16'd0, 16'd1, 16'd2, 16'd0, 16'd1, 16'd2};
    do_reset();
    wr(A_CMP, 16'd2);
    wr(A_CTRL, 16'h0003);
    for (int i = 0; i < 6; i++) rd(A_COUNT, seq[i], "reload_seq");
    rd(A_STAT, 16'd1, "reload_match");
  endtask

  task automatic test_w1c();
    do_reset();
    wr(A_CMP, 16'd2);
    wr(A_CTRL, 16'h0007);
    idle(3);
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL w1c_first: got %b want 1", irq);
    end
    idle(2);
    wr(A_STAT, 16'h0001);
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL w1c_setwins: got %b want 1", irq);
    end
    rd(A_STAT, 16'd1, "w1c_setwins_rd");
    wr(A_CTRL, 16'h0004);
    wr(A_STAT, 16'h0001);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL w1c_clear_irq: got %b want 0", irq);
    end
    rd(A_STAT, 16'd0, "w1c_clear_rd");
  endtask

  task automatic test_decode();
    logic [8:0] bad [3];
    bad = '{9'h17F, 9'h184, 9'h100};
    do_reset();
    wr(A_CMP, 16'h1234);
    rd(A_CMP, 16'h1234, "dec_setup");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_cmd = 2'b10;
      mem_addr = bad[i];
      write_data = 16'hFFFF;
      #1;
      n_vec++;
      if (read_en !== 1'b0) begin
        n_err++;
        $display("FAIL dec_wr_en %h: got %b want 0", bad[i], read_en);
      end
      @(negedge clk);
      mem_cmd = 2'b01;
      #1;
      n_vec++;
      if (read_en !== 1'b0) begin
        n_err++;
        $display("FAIL dec_rd_en %h: got %b want 0", bad[i], read_en);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (read_data !== 16'h1234) begin
        n_err++;
        $display("FAIL dec_hold %h: got %h want 1234",
                 bad[i], read_data);
      end
    end
    @(negedge clk);
    mem_cmd = 2'b11;
    mem_addr = A_CTRL;
    write_data = 16'hFFFF;
    #1;
    n_vec++;
    if (read_en !== 1'b0) begin
      n_err++;
      $display("FAIL dec_cmd11_en: got %b want 0", read_en);
    end
    rd(A_CTRL, 16'h0000, "dec_ctrl");
    rd(A_COUNT, 16'h0000, "dec_count");
    rd(A_CMP, 16'h1234, "dec_cmp");
    rd(A_STAT, 16'h0000, "dec_stat");
  endtask

  task automatic test_reset_midcount();
    do_reset();
    wr(A_CMP, 16'h0011);
    wr(A_COUNT, 16'h0010);
    wr(A_CTRL, 16'h0005);
    idle(2);
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL mid_irq_pre: got %b want 1", irq);
    end
    rd(A_CMP, 16'h0011, "mid_cmp_pre");
    @(negedge clk);
    reset = 1'b1;
    mem_cmd = 2'b10;
    mem_addr = A_COUNT;
    write_data = 16'h0055;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_cmd = 2'b00;
    n_vec++;
    if (read_data !== 16'h0000) begin
      n_err++;
      $display("FAIL mid_rdata: got %h want 0000", read_data);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL mid_irq: got %b want 0", irq);
    end
    rd(A_CTRL, 16'h0000, "mid_ctrl");
    rd(A_COUNT, 16'h0000, "mid_count");
    rd(A_CMP, 16'h0000, "mid_cmp");
    rd(A_STAT, 16'h0000, "mid_stat");
  endtask

  initial begin
    reset = 1'b1;
    mem_cmd = 2'b00;
    mem_addr = 9'h000;
    write_data = 16'h0000;
    test_reset();
    test_regs();
    test_count_match();
    test_prescale();
    test_wrap();
    test_reload();
    test_w1c();
    test_decode();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
